hyperbus_ctrl: RTL and testbench

// Single-clock HyperBus transaction engine between a simple request/stream interface and the

---
 rtl/hyperbus_ctrl.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_hyperbus_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hyperbus_ctrl.sv
// HyperBus transaction engine: command/address, fixed 2x initial latency, then word bursts.
// clk_i runs at twice CK, so every clk cycle is one CK edge and carries one DQ byte.
module hyperbus_ctrl #(
    parameter int NumChips      = 1,
    parameter int LatencyCycles = 6,
    parameter int TimeoutCycles = 64,
    parameter int RecoverCycles = 4,
    localparam int CsW          = (NumChips > 1) ? $clog2(NumChips) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_write_i,
    input  logic                req_regspace_i,
    input  logic [31:0]         req_addr_i,
    input  logic [7:0]          req_len_i,
    input  logic [CsW-1:0]      req_cs_i,
    input  logic                wdata_valid_i,
    output logic                wdata_ready_o,
    input  logic [15:0]         wdata_i,
    input  logic [1:0]          wstrb_i,
    output logic                rdata_valid_o,
    output logic [15:0]         rdata_o,
    output logic                rdata_last_o,
    output logic                done_o,
    output logic                error_o,
    output logic [NumChips-1:0] hyper_cs_no,
    output logic                hyper_ck_o,
    output logic                hyper_ck_no,
    output logic                hyper_reset_no,
    output logic [7:0]          hyper_dq_o,
    input  logic [7:0]          hyper_dq_i,
    output logic                hyper_dq_oe_o,
    output logic                hyper_rwds_o,
    input  logic                hyper_rwds_i,
    output logic                hyper_rwds_oe_o
);
    localparam int CntW = 16;
    localparam int TmoW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [CntW-1:0] CaLast  = CntW'(5);
    localparam logic [CntW-1:0] LatLast = CntW'(4 * LatencyCycles - 1);
    localparam logic [CntW-1:0] LatDrv  = CntW'(4 * LatencyCycles - 2);
    localparam logic [CntW-1:0] RecLast = CntW'(RecoverCycles - 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCycles - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CS_SETUP, S_CA, S_LAT, S_WDATA, S_RDATA, S_CS_HOLD, S_RECOVER
    } state_t;

    state_t          r_state, w_state_nx;
    logic [CntW-1:0] r_cnt, w_cnt_nx;
    logic [TmoW-1:0] r_tmo, w_tmo_nx;
    logic            r_ph, w_ph_nx;
    logic [7:0]      r_wcnt, w_wcnt_nx;
    logic            r_err, w_err_nx;
    logic            r_rwds_q;
    logic            r_rvalid;
    logic            r_rlast;
    logic            r_reset_n;

    logic            r_write;
    logic            r_regspace;
    logic [31:0]     r_addr;
    logic [7:0]      r_len;
    logic [CsW-1:0]  r_cs;
    logic [15:0]     r_word;
    logic [1:0]      r_strb;
    logic [7:0]      r_rhi;
    logic [15:0]     r_rdata;

    logic            w_accept;
    logic            w_wtake;
    logic            w_rwds_edge;
    logic            w_rhi_ld;
    logic            w_rword_ld;
    logic            w_cs_act;
    logic [47:0]     w_ca;
    logic [7:0]      w_ca_byte;
    logic            w_rwds_val;

    assign w_ca        = {~r_write, r_regspace, 1'b1, r_addr[31:3], 13'd0, r_addr[2:0]};
    assign w_rwds_edge = (r_state == S_RDATA) && (hyper_rwds_i != r_rwds_q);

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_tmo_nx   = r_tmo;
        w_ph_nx    = r_ph;
        w_wcnt_nx  = r_wcnt;
        w_err_nx   = r_err;
        w_accept   = 1'b0;
        w_wtake    = 1'b0;
        w_rhi_ld   = 1'b0;
        w_rword_ld = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid_i && r_reset_n) begin
                    w_accept   = 1'b1;
                    w_err_nx   = 1'b0;
                    w_state_nx = S_CS_SETUP;
                end
            end
            S_CS_SETUP: begin
                w_cnt_nx   = '0;
                w_state_nx = S_CA;
            end
            S_CA: begin
                if (r_cnt == CaLast) begin
                    w_cnt_nx   = '0;
                    w_state_nx = S_LAT;
                end else begin
                    w_cnt_nx = r_cnt + CntW'(1);
                end
            end
            S_LAT: begin
                if (r_cnt == LatLast) begin
                    w_cnt_nx   = '0;
                    w_tmo_nx   = '0;
                    w_ph_nx    = 1'b0;
                    w_wcnt_nx  = '0;
                    w_state_nx = r_write ? S_WDATA : S_RDATA;
                end else begin
                    w_cnt_nx = r_cnt + CntW'(1);
                end
            end
            S_WDATA: begin
                // High-byte slot waits for a word; waiting here stretches CK low.
                if (!r_ph) begin
                    if (wdata_valid_i) begin
                        w_wtake = 1'b1;
                        w_ph_nx = 1'b1;
                    end
                end else begin
                    w_ph_nx = 1'b0;
                    if (r_wcnt == r_len) begin
                        w_state_nx = S_CS_HOLD;
                    end else begin
                        w_wcnt_nx = r_wcnt + 8'd1;
                    end
                end
            end
            S_RDATA: begin
                w_cnt_nx = r_cnt + CntW'(1);
                if (w_rwds_edge) begin
                    w_tmo_nx = '0;
                    w_ph_nx  = ~r_ph;
                    if (!r_ph) begin
                        w_rhi_ld = 1'b1;
                    end else begin
                        w_rword_ld = 1'b1;
                        w_wcnt_nx  = r_wcnt + 8'd1;
                        if (r_wcnt == r_len) begin
                            w_state_nx = S_CS_HOLD;
                        end
                    end
                end else if (r_tmo == TmoLast) begin
                    w_err_nx   = 1'b1;
                    w_state_nx = S_CS_HOLD;
                end else begin
                    w_tmo_nx = r_tmo + TmoW'(1);
                end
            end
            S_CS_HOLD: begin
                w_cnt_nx   = '0;
                w_state_nx = S_RECOVER;
            end
            S_RECOVER: begin
                if (r_cnt == RecLast) begin
                    w_state_nx = S_IDLE;
                end else begin
                    w_cnt_nx = r_cnt + CntW'(1);
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_tmo     <= '0;
            r_ph      <= 1'b0;
            r_wcnt    <= '0;
            r_err     <= 1'b0;
            r_rwds_q  <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_reset_n <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_tmo     <= w_tmo_nx;
            r_ph      <= w_ph_nx;
            r_wcnt    <= w_wcnt_nx;
            r_err     <= w_err_nx;
            r_rwds_q  <= (r_state == S_RDATA) ? hyper_rwds_i : 1'b0;
            r_rvalid  <= w_rword_ld;
            r_rlast   <= w_rword_ld && (r_wcnt == r_len);
            r_reset_n <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_write    <= req_write_i;
            r_regspace <= req_regspace_i;
            r_addr     <= req_addr_i;
            r_len      <= req_len_i;
            r_cs       <= req_cs_i;
            r_word     <= '0;
            r_strb     <= 2'b11;
        end
        if (w_wtake) begin
            r_word <= wdata_i;
            r_strb <= wstrb_i;
        end
        if (w_rhi_ld) begin
            r_rhi <= hyper_dq_i;
        end
        if (w_rword_ld) begin
            r_rdata <= {r_rhi, hyper_dq_i};
        end
    end

    always_comb begin
        case (r_cnt[2:0])
            3'd0:    w_ca_byte = w_ca[47:40];
            3'd1:    w_ca_byte = w_ca[39:32];
            3'd2:    w_ca_byte = w_ca[31:24];
            3'd3:    w_ca_byte = w_ca[23:16];
            3'd4:    w_ca_byte = w_ca[15:8];
            3'd5:    w_ca_byte = w_ca[7:0];
            default: w_ca_byte = 8'h00;
        endcase
    end

    assign w_cs_act = (r_state != S_IDLE) && (r_state != S_RECOVER);

    always_comb begin
        for (int c = 0; c < NumChips; c++) begin
            hyper_cs_no[c] = !(w_cs_act && (int'(r_cs) == c));
        end
    end

    // Pad drive; the stalled high-byte slot keeps the last low byte and its mask on the bus.
    always_comb begin
        hyper_ck_o    = 1'b0;
        hyper_dq_o    = 8'h00;
        hyper_dq_oe_o = 1'b0;
        w_rwds_val    = 1'b0;
        wdata_ready_o = 1'b0;
        case (r_state)
            S_CA: begin
                hyper_ck_o    = ~r_cnt[0];
                hyper_dq_o    = w_ca_byte;
                hyper_dq_oe_o = 1'b1;
            end
            S_LAT: begin
                hyper_ck_o    = ~r_cnt[0];
                hyper_dq_oe_o = r_write && (r_cnt >= LatDrv);
            end
            S_WDATA: begin
                hyper_dq_oe_o = 1'b1;
                hyper_dq_o    = r_word[7:0];
                w_rwds_val    = ~r_strb[0];
                if (!r_ph) begin
                    wdata_ready_o = 1'b1;
                    if (wdata_valid_i) begin
                        hyper_ck_o = 1'b1;
                        hyper_dq_o = wdata_i[15:8];
                        w_rwds_val = ~wstrb_i[1];
                    end
                end
            end
            S_RDATA: begin
                hyper_ck_o = ~r_cnt[0];
            end
            default: ;
        endcase
    end

    assign hyper_rwds_oe_o = (r_state == S_WDATA) && !r_regspace;
    assign hyper_rwds_o    = hyper_rwds_oe_o && w_rwds_val;
    assign hyper_ck_no     = ~hyper_ck_o;
    assign hyper_reset_no  = r_reset_n;
    assign req_ready_o     = (r_state == S_IDLE) && r_reset_n;
    assign done_o          = (r_state == S_CS_HOLD);
    assign error_o         = (r_state == S_CS_HOLD) && r_err;
    assign rdata_valid_o   = r_rvalid;
    assign rdata_last_o    = r_rlast;
    assign rdata_o         = r_rdata;

endmodule

// File: tb/tb_hyperbus_ctrl.sv
// Directed bench for hyperbus_ctrl: per-cycle pad log with hand-computed expectations.
module tb_hyperbus_ctrl;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i, req_ready_o, req_write_i, req_regspace_i;
    logic [31:0] req_addr_i;
    logic [7:0]  req_len_i;
    logic [0:0]  req_cs_i;
    logic        wdata_valid_i, wdata_ready_o;
    logic [15:0] wdata_i;
    logic [1:0]  wstrb_i;
    logic        rdata_valid_o, rdata_last_o, done_o, error_o;
    logic [15:0] rdata_o;
    logic [0:0]  hyper_cs_no;
    logic        hyper_ck_o, hyper_ck_no, hyper_reset_no;
    logic [7:0]  hyper_dq_o, hyper_dq_i;
    logic        hyper_dq_oe_o, hyper_rwds_o, hyper_rwds_i, hyper_rwds_oe_o;

    hyperbus_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
        .req_regspace_i(req_regspace_i), .req_addr_i(req_addr_i), .req_len_i(req_len_i),
        .req_cs_i(req_cs_i), .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o),
        .wdata_i(wdata_i), .wstrb_i(wstrb_i), .rdata_valid_o(rdata_valid_o), .rdata_o(rdata_o),
        .rdata_last_o(rdata_last_o), .done_o(done_o), .error_o(error_o),
        .hyper_cs_no(hyper_cs_no), .hyper_ck_o(hyper_ck_o), .hyper_ck_no(hyper_ck_no),
        .hyper_reset_no(hyper_reset_no), .hyper_dq_o(hyper_dq_o), .hyper_dq_i(hyper_dq_i),
        .hyper_dq_oe_o(hyper_dq_oe_o), .hyper_rwds_o(hyper_rwds_o), .hyper_rwds_i(hyper_rwds_i),
        .hyper_rwds_oe_o(hyper_rwds_oe_o)
    );

    always #5 clk_i = ~clk_i;

    localparam int LogN = 128;
    logic [7:0]  l_dq [LogN];
    logic [15:0] l_rd [LogN];
    logic        l_ck [LogN], l_cs [LogN], l_dqoe [LogN], l_rwds [LogN], l_rwdsoe [LogN];
    logic        l_done [LogN], l_err [LogN], l_rv [LogN], l_rl [LogN], l_rdy [LogN];
    logic        l_wrdy [LogN];
    logic [7:0]  m_dq [LogN];
    logic        m_rwds [LogN], m_stall [LogN];
    logic [15:0] src_w [8];
    logic [1:0]  src_s [8];
    int          src_n, widx;
    logic        q_write;
    logic [31:0] q_addr;
    logic [7:0]  q_len;
    int          n_chk = 0, n_pass = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < LogN; i++) begin
            m_dq[i] = 8'h00;
            m_rwds[i] = 1'b0;
            m_stall[i] = 1'b0;
        end
        widx = 0;
        src_n = 0;
    endtask

    // Cycle 0 presents the request in IDLE; each entry is sampled 1 time unit after a negedge.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            req_valid_i    = (i == 0);
            req_write_i    = q_write;
            req_addr_i     = q_addr;
            req_len_i      = q_len;
            wdata_valid_i  = !m_stall[i] && (widx < src_n);
            wdata_i        = (widx < src_n) ? src_w[widx] : 16'h0000;
            wstrb_i        = (widx < src_n) ? src_s[widx] : 2'b00;
            hyper_dq_i     = m_dq[i];
            hyper_rwds_i   = m_rwds[i];
            #1;
            l_dq[i]     = hyper_dq_o;
            l_rd[i]     = rdata_o;
            l_ck[i]     = hyper_ck_o;
            l_cs[i]     = hyper_cs_no[0];
            l_dqoe[i]   = hyper_dq_oe_o;
            l_rwds[i]   = hyper_rwds_o;
            l_rwdsoe[i] = hyper_rwds_oe_o;
            l_done[i]   = done_o;
            l_err[i]    = error_o;
            l_rv[i]     = rdata_valid_o;
            l_rl[i]     = rdata_last_o;
            l_rdy[i]    = req_ready_o;
            l_wrdy[i]   = wdata_ready_o;
            if (wdata_ready_o && wdata_valid_i) widx++;
        end
    endtask

    initial begin
        logic [7:0] ca_exp [6];
        int cnt;
        ca_exp = '{8'h20, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00};
        rst_i = 1'b1;
        req_valid_i = 1'b0; req_write_i = 1'b0; req_regspace_i = 1'b0;
        req_addr_i = '0; req_len_i = '0; req_cs_i = '0;
        wdata_valid_i = 1'b0; wdata_i = '0; wstrb_i = '0;
        hyper_dq_i = '0; hyper_rwds_i = 1'b0;
        q_write = 1'b0; q_addr = '0; q_len = '0;
        clear_model();

        // Reset values and reset_no release
        @(negedge clk_i); @(negedge clk_i); #1;
        chk("rst_cs_n", hyper_cs_no, 1);
        chk("rst_ck", hyper_ck_o, 0);
        chk("rst_ck_n", hyper_ck_no, 1);
        chk("rst_dq_oe", hyper_dq_oe_o, 0);
        chk("rst_rwds_oe", hyper_rwds_oe_o, 0);
        chk("rst_dq", hyper_dq_o, 0);
        chk("rst_reset_n", hyper_reset_no, 0);
        chk("rst_ready", req_ready_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_rvalid", rdata_valid_o, 0);
        @(negedge clk_i); rst_i = 1'b0; #1;
        chk("rel_reset_n_still0", hyper_reset_no, 0);
        @(negedge clk_i); #1;
        chk("rel_reset_n", hyper_reset_no, 1);
        chk("rel_ready", req_ready_o, 1);

        // Single-word write of 0xBEEF to address 0x10
        clear_model();
        src_w[0] = 16'hBEEF; src_s[0] = 2'b11; src_n = 1;
        q_write = 1'b1; q_addr = 32'h0000_0010; q_len = 8'd0;
        run(40);
        chk("w_idle_cs", l_cs[0], 1);
        chk("w_setup_cs", l_cs[1], 0);
        chk("w_setup_ck", l_ck[1], 0);
        chk("w_ca_ck0", l_ck[2], 1);
        chk("w_ca_ck1", l_ck[3], 0);
        for (int k = 0; k < 6; k++) chk($sformatf("w_ca_byte%0d", k), l_dq[2+k], ca_exp[k]);
        chk("w_ca_oe", l_dqoe[2], 1);
        chk("w_lat_oe_early", l_dqoe[29], 0);
        chk("w_lat_oe_last2", l_dqoe[30], 1);
        chk("w_lat_rwds_oe", l_rwdsoe[31], 0);
        chk("w_hi_byte", l_dq[32], 8'hBE);
        chk("w_hi_ck", l_ck[32], 1);
        chk("w_hi_rwds_oe", l_rwdsoe[32], 1);
        chk("w_hi_rwds", l_rwds[32], 0);
        chk("w_hi_wready", l_wrdy[32], 1);
        chk("w_lo_byte", l_dq[33], 8'hEF);
        chk("w_lo_rwds", l_rwds[33], 0);
        chk("w_lo_ck", l_ck[33], 0);
        cnt = 0;
        for (int i = 0; i < 40; i++) cnt += int'(l_done[i]);
        chk("w_done_count", cnt, 1);
        chk("w_done_at_hold", l_done[34], 1);
        chk("w_hold_cs", l_cs[34], 0);
        cnt = 0;
        for (int i = 35; i < 39; i++) cnt += int'(l_cs[i]);
        chk("w_recover_cs_high", cnt, 4);
        chk("w_recover_ready", l_rdy[38], 0);
        chk("w_idle_ready", l_rdy[39], 1);

        // Byte-masked write: strobe 01 masks the high byte
        clear_model();
        src_w[0] = 16'h1234; src_s[0] = 2'b01; src_n = 1;
        q_write = 1'b1; q_addr = 32'h0000_0010; q_len = 8'd0;
        run(40);
        chk("m_hi_byte", l_dq[32], 8'h12);
        chk("m_hi_rwds", l_rwds[32], 1);
        chk("m_lo_byte", l_dq[33], 8'h34);
        chk("m_lo_rwds", l_rwds[33], 0);

        // Four-word read against a byte-stream chip model
        clear_model();
        for (int b = 0; b < 8; b++) begin
            m_dq[34+b] = 8'(8'h11 * (b + 1));
            m_rwds[34+b] = (b % 2 == 0);
        end
        q_write = 1'b0; q_addr = 32'h0000_0000; q_len = 8'd3;
        run(48);
        chk("r_ca_byte0", l_dq[2], 8'hA0);
        chk("r_lat_oe", l_dqoe[30], 0);
        chk("r_data_oe", l_dqoe[35], 0);
        chk("r_data_rwds_oe", l_rwdsoe[35], 0);
        cnt = 0;
        for (int i = 0; i < 48; i++) cnt += int'(l_rv[i]);
        chk("r_valid_count", cnt, 4);
        chk("r_word0", {l_rv[36], l_rd[36]}, {1'b1, 16'h1122});
        chk("r_word1", {l_rv[38], l_rd[38]}, {1'b1, 16'h3344});
        chk("r_word2", {l_rv[40], l_rd[40], l_rl[40]}, {1'b1, 16'h5566, 1'b0});
        chk("r_word3", {l_rv[42], l_rd[42], l_rl[42]}, {1'b1, 16'h7788, 1'b1});
        chk("r_done", l_done[42], 1);
        chk("r_no_error", l_err[42], 0);

        // Read with RWDS never toggling
        clear_model();
        q_write = 1'b0; q_addr = 32'h0000_0100; q_len = 8'd0;
        run(102);
        chk("t_no_done_early", l_done[95], 0);
        chk("t_done", l_done[96], 1);
        chk("t_error", l_err[96], 1);
        cnt = 0;
        for (int i = 0; i < 102; i++) cnt += int'(l_rv[i]);
        chk("t_no_rdata", cnt, 0);
        cnt = 0;
        for (int i = 0; i < 102; i++) cnt += int'(l_done[i]);
        chk("t_done_count", cnt, 1);

        // Two-word write with the stream stalled five cycles at the word boundary
        clear_model();
        src_w[0] = 16'hA55A; src_s[0] = 2'b11;
        src_w[1] = 16'h1357; src_s[1] = 2'b11; src_n = 2;
        for (int i = 34; i < 39; i++) m_stall[i] = 1'b1;
        q_write = 1'b1; q_addr = 32'h0000_0040; q_len = 8'd1;
        run(47);
        chk("s_w0_hi", l_dq[32], 8'hA5);
        chk("s_w0_lo", l_dq[33], 8'h5A);
        cnt = 0;
        for (int i = 33; i < 39; i++) cnt += int'(!l_ck[i]);
        chk("s_ck_frozen", cnt, 6);
        cnt = 0;
        for (int i = 34; i < 39; i++) cnt += int'(l_dq[i] == 8'h5A && !l_rwds[i]);
        chk("s_dq_held", cnt, 5);
        chk("s_resume_ck", l_ck[39], 1);
        chk("s_w1_hi", l_dq[39], 8'h13);
        chk("s_w1_lo", l_dq[40], 8'h57);
        chk("s_done", l_done[41], 1);
        chk("s_words_taken", widx, 2);

        // Asynchronous reset in the middle of the command phase
        clear_model();
        src_w[0] = 16'hCAFE; src_s[0] = 2'b11; src_n = 1;
        q_write = 1'b1; q_addr = 32'h0000_0000; q_len = 8'd0;
        run(5);
        chk("a_cs_active", l_cs[4], 0);
        #1 rst_i = 1'b1;
        #1;
        chk("a_cs_released", hyper_cs_no, 1);
        chk("a_ck_low", hyper_ck_o, 0);
        chk("a_dq_oe", hyper_dq_oe_o, 0);
        chk("a_no_done", done_o, 0);
        chk("a_reset_n", hyper_reset_no, 0);
        @(negedge clk_i); rst_i = 1'b0;
        @(negedge clk_i); #1;
        chk("a_ready_after", req_ready_o, 1);
        chk("a_done_after", done_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
